cl_frame_arbiter: RTL and testbench

CL_FRAME_ARBITER -- requirements
Module: cl_frame_arbiter

---
 rtl/cl_frame_arbiter.sv | 152 +++++++++++++++
 tb/tb_cl_frame_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_frame_arbiter.sv
// cl_frame_arbiter: two-source round-robin Camera Link frame arbiter with sync-aligned frame starts.
// Define CL_ARB_TIMEOUT_EN to enable the BUSY watchdog and sticky timeout_err.
module cl_frame_arbiter #(
  parameter int          SYNC_HALF  = 2000000,
  parameter int          GAP_CYCLES = 163,
  parameter logic [23:0] TIMEOUT    = 24'd4000000
) (
  input  logic        pClk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic        sync_ext,
  input  logic        sync_sel,
  input  logic        pause,
  input  logic        tx_busy,
  input  logic        frame_done,
  output logic [1:0]  grant,
  output logic        src_sel,
  output logic        frame_start,
  output logic [2:0]  arb_state,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1,
  output logic        timeout_err
);
  localparam int SW = (SYNC_HALF > 0) ? $clog2(SYNC_HALF + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SYNC = 3'd1,
    START     = 3'd2,
    BUSY      = 3'd3,
    GAP       = 3'd4
  } state_t;
  state_t      r_state;
  logic [SW-1:0] r_sync_cnt;
  logic        r_sync_int;
  logic [1:0]  r_sync_q;
  logic [GW-1:0] r_gap;
  logic [1:0]  r_grant;
  logic        r_win;
  logic        r_last;
  logic        r_frame_start;
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;
  logic        w_sync_wrap;
  logic        w_sync_in;
  logic        w_sync_fall;
  logic        w_pick;
  logic [1:0]  w_onehot;
  assign w_sync_wrap = r_sync_cnt == SW'(SYNC_HALF);
  assign w_sync_in   = sync_sel ? sync_ext : r_sync_int;
  // r_sync_q[1] is the older stage; a fall is older=1, newer=0
  assign w_sync_fall = r_sync_q[1] & ~r_sync_q[0];
  assign w_pick      = (&req) ? ~r_last : req[1];
  assign w_onehot    = r_win ? 2'b10 : 2'b01;
  always_ff @(posedge pClk) begin
    if (rst) begin
      r_sync_cnt <= '0;
      r_sync_int <= 1'b0;
      r_sync_q   <= '0;
    end else begin
      r_sync_cnt <= w_sync_wrap ? '0 : r_sync_cnt + 1'b1;
      r_sync_int <= r_sync_int ^ w_sync_wrap;
      r_sync_q   <= {r_sync_q[0], w_sync_in};
    end
  end
`ifdef CL_ARB_TIMEOUT_EN
  logic [23:0] r_to_cnt;
  logic        r_to_err;
  assign timeout_err = r_to_err;
`else
  logic [23:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT;
  assign timeout_err      = 1'b0;
`endif
  always_ff @(posedge pClk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_win         <= 1'b0;
      r_last        <= 1'b1;
      r_frame_start <= 1'b0;
      r_cnt0        <= '0;
      r_cnt1        <= '0;
      r_gap         <= '0;
`ifdef CL_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_to_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req != 2'b00 && !pause) begin
            r_win   <= w_pick;
            r_state <= WAIT_SYNC;
          end
        end
        WAIT_SYNC: begin
          if (!req[r_win]) begin
            r_state <= IDLE;
          end else if (w_sync_fall && !pause && !tx_busy) begin
            r_frame_start <= 1'b1;
            r_grant       <= w_onehot;
            r_state       <= START;
          end
        end
        START: begin
          r_frame_start <= 1'b0;
          r_state       <= BUSY;
`ifdef CL_ARB_TIMEOUT_EN
          r_to_cnt      <= '0;
`endif
        end
        BUSY: begin
          if (frame_done) begin
            if (r_win) r_cnt1 <= r_cnt1 + 16'd1;
            else r_cnt0 <= r_cnt0 + 16'd1;
            r_last  <= r_win;
            r_grant <= '0;
            r_gap   <= '0;
            r_state <= GAP;
          end
`ifdef CL_ARB_TIMEOUT_EN
          else if (r_to_cnt == TIMEOUT - 24'd1) begin
            r_to_err <= 1'b1;
            r_grant  <= '0;
            r_gap    <= '0;
            r_state  <= GAP;
          end else begin
            r_to_cnt <= r_to_cnt + 24'd1;
          end
`endif
        end
        GAP: begin
          if (r_gap == GW'(GAP_CYCLES - 1)) r_state <= IDLE;
          else r_gap <= r_gap + 1'b1;
        end
        default: begin
          r_state       <= IDLE;
          r_grant       <= '0;
          r_win         <= 1'b0;
          r_frame_start <= 1'b0;
        end
      endcase
    end
  end
  assign grant       = r_grant;
  assign src_sel     = r_win;
  assign frame_start = r_frame_start;
  assign arb_state   = r_state;
  assign frame_cnt0  = r_cnt0;
  assign frame_cnt1  = r_cnt1;
endmodule

// File: tb/tb_cl_frame_arbiter.sv
// tb_cl_frame_arbiter: randomized self-checking bench for cl_frame_arbiter against a frame-level model.
module tb_cl_frame_arbiter;
  localparam int SH = 15;
  localparam int GC = 4;
  logic        pClk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic        sync_ext = 1'b1;
  logic        sync_sel = 1'b0;
  logic        pause = 1'b0;
  logic        tx_busy = 1'b0;
  logic        frame_done = 1'b0;
  logic [1:0]  grant;
  logic        src_sel;
  logic        frame_start;
  logic [2:0]  arb_state;
  logic [15:0] frame_cnt0;
  logic [15:0] frame_cnt1;
  logic        timeout_err;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = -1;
  int m_cnt [2] = '{0, 0};
  bit m_last = 1'b1;

  cl_frame_arbiter #(.SYNC_HALF(SH), .GAP_CYCLES(GC), .TIMEOUT(24'd100)) dut (
    .pClk(pClk), .rst(rst), .req(req), .sync_ext(sync_ext), .sync_sel(sync_sel),
    .pause(pause), .tx_busy(tx_busy), .frame_done(frame_done), .grant(grant),
    .src_sel(src_sel), .frame_start(frame_start), .arb_state(arb_state),
    .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1), .timeout_err(timeout_err)
  );

  always #5 pClk = ~pClk;

  task automatic tick;
    @(posedge pClk);
    #1;
    cyc++;
  endtask

  function automatic logic [1:0] onehot(input bit w);
    return w ? 2'b10 : 2'b01;
  endfunction

  task automatic test_reset;
    rst = 1'b1; req = 2'b00; sync_sel = 1'b0; sync_ext = 1'b1;
    pause = 1'b0; tx_busy = 1'b0; frame_done = 1'b0;
    repeat (3) tick;
    m_last = 1'b1; m_cnt = '{0, 0};
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (arb_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", arb_state); end
    checks++; if (frame_start !== 1'b0 || src_sel !== 1'b0) begin errors++; $display("FAIL reset_start_sel: got %b/%b want 0/0", frame_start, src_sel); end
    checks++; if (frame_cnt0 !== 16'd0 || frame_cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", frame_cnt0, frame_cnt1); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
  endtask

  task automatic test_internal_sync;
    int first = 0;
    int n = 0;
    req = 2'b01; rst = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      tick;
      if (frame_start === 1'b1) begin
        n++;
        if (first == 0) first = e;
      end
    end
    // internal sync rises after SH+1 edges, falls after 2*(SH+1), start two edges later
    checks++; if (first != 2 * (SH + 1) + 2) begin errors++; $display("FAIL int_sync_start: got edge %0d want %0d", first, 2 * (SH + 1) + 2); end
    checks++; if (n != 1) begin errors++; $display("FAIL int_sync_pulses: got %0d want 1", n); end
    checks++; if (grant !== 2'b01 || src_sel !== 1'b0 || arb_state !== 3'd3) begin errors++; $display("FAIL int_sync_busy: grant=%b sel=%b state=%0d want 01/0/3", grant, src_sel, arb_state); end
    frame_done = 1'b1; tick; frame_done = 1'b0;
    m_cnt[0]++; m_last = 1'b0;
    checks++; if (frame_cnt0 !== 16'(m_cnt[0]) || grant !== 2'b00) begin errors++; $display("FAIL int_sync_done: cnt0=%0d grant=%b want %0d/00", frame_cnt0, grant, m_cnt[0]); end
    req = 2'b00;
    repeat (GC) tick;
    checks++; if (arb_state !== 3'd0) begin errors++; $display("FAIL int_sync_idle: got %0d want 0", arb_state); end
    sync_sel = 1'b1; sync_ext = 1'b1;
    repeat (2) tick;
  endtask

  task automatic test_withdraw;
    req = 2'b10; tick;
    checks++; if (arb_state !== 3'd1 || src_sel !== 1'b1) begin errors++; $display("FAIL withdraw_latch: state=%0d sel=%b want 1/1", arb_state, src_sel); end
    req = 2'b00; tick;
    checks++; if (arb_state !== 3'd0 || grant !== 2'b00) begin errors++; $display("FAIL withdraw_idle: state=%0d grant=%b want 0/00", arb_state, grant); end
  endtask

  // blocked: 0 none, 1 pause at the first sync fall, 2 tx_busy at the first sync fall
  task automatic run_frame(input logic [1:0] r, input int blocked, input bit fast,
                           input bit hold_pause, input int len, output logic [1:0] g);
    bit w;
    bit seen;
    w = (r == 2'b11) ? ~m_last : r[1];
    req = r;
    if (fast) begin
      sync_ext = 1'b0; tick;
      checks++; if (arb_state !== 3'd1 || frame_start !== 1'b0 || src_sel !== w) begin errors++; $display("FAIL fast_latch: state=%0d start=%b sel=%b want 1/0/%b", arb_state, frame_start, src_sel, w); end
    end else begin
      tick;
      checks++; if (arb_state !== 3'd1 || src_sel !== w || grant !== 2'b00) begin errors++; $display("FAIL latch: state=%0d sel=%b grant=%b want 1/%b/00", arb_state, src_sel, grant, w); end
      if (blocked != 0) begin
        if (blocked == 1) pause = 1'b1; else tx_busy = 1'b1;
        sync_ext = 1'b0; frame_done = 1'b1; tick; frame_done = 1'b0;
        seen = frame_start;
        tick; seen |= frame_start;
        tick; seen |= frame_start;
        sync_ext = 1'b1; tick; seen |= frame_start;
        pause = 1'b0; tx_busy = 1'b0;
        checks++; if (seen || arb_state !== 3'd1 || frame_cnt0 !== 16'(m_cnt[0]) || frame_cnt1 !== 16'(m_cnt[1])) begin errors++; $display("FAIL blocked_edge: start_seen=%b state=%0d cnt=%0d/%0d want 0/1/%0d/%0d", seen, arb_state, frame_cnt0, frame_cnt1, m_cnt[0], m_cnt[1]); end
      end
      sync_ext = 1'b0; tick;
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL start_early: got %b want 0", frame_start); end
    end
    tick;
    g = grant;
    checks++; if (frame_start !== 1'b1 || grant !== onehot(w) || arb_state !== 3'd2 || src_sel !== w) begin errors++; $display("FAIL start: start=%b grant=%b state=%0d sel=%b want 1/%b/2/%b", frame_start, grant, arb_state, src_sel, onehot(w), w); end
    if (fast) begin
      checks++; if (cyc - done_cyc != GC + 2) begin errors++; $display("FAIL latency: got %0d edges want %0d", cyc - done_cyc, GC + 2); end
    end
    sync_ext = 1'b1; pause = hold_pause; tick;
    checks++; if (arb_state !== 3'd3 || frame_start !== 1'b0 || grant !== onehot(w)) begin errors++; $display("FAIL busy_entry: state=%0d start=%b grant=%b want 3/0/%b", arb_state, frame_start, grant, onehot(w)); end
    for (int i = 0; i < len; i++) begin
      pause = 1'($urandom_range(1)); tx_busy = 1'($urandom_range(1)); tick;
      checks++; if (grant !== onehot(w) || arb_state !== 3'd3) begin errors++; $display("FAIL busy_hold: grant=%b state=%0d want %b/3", grant, arb_state, onehot(w)); end
    end
    pause = 1'b0; tx_busy = 1'b0; frame_done = 1'b1; tick; frame_done = 1'b0;
    done_cyc = cyc;
    m_cnt[w]++; m_last = w;
    checks++; if (grant !== 2'b00 || arb_state !== 3'd4) begin errors++; $display("FAIL done: grant=%b state=%0d want 00/4", grant, arb_state); end
    checks++; if (frame_cnt0 !== 16'(m_cnt[0]) || frame_cnt1 !== 16'(m_cnt[1])) begin errors++; $display("FAIL count: got %0d/%0d want %0d/%0d", frame_cnt0, frame_cnt1, m_cnt[0], m_cnt[1]); end
    for (int i = 1; i < GC; i++) begin
      tick;
      checks++; if (arb_state !== 3'd4 || grant !== 2'b00) begin errors++; $display("FAIL gap: state=%0d grant=%b want 4/00", arb_state, grant); end
    end
    tick;
    checks++; if (arb_state !== 3'd0) begin errors++; $display("FAIL gap_end: got %0d want 0", arb_state); end
  endtask

  task automatic test_pause_sync;
    logic [1:0] g;
    run_frame(2'b01, 1, 1'b0, 1'b1, 3, g);
    run_frame(2'b10, 2, 1'b0, 1'b0, 2, g);
    req = 2'b00;
  endtask

  task automatic test_reset_mid_busy;
    req = 2'b10; tick;
    sync_ext = 1'b0; tick; tick;
    sync_ext = 1'b1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rst_pre_grant: got %b want 10", grant); end
    tick; tick;
    rst = 1'b1; tick;
    checks++; if (grant !== 2'b00 || arb_state !== 3'd0 || frame_start !== 1'b0 || src_sel !== 1'b0) begin errors++; $display("FAIL rst_mid: grant=%b state=%0d start=%b sel=%b want 00/0/0/0", grant, arb_state, frame_start, src_sel); end
    checks++; if (frame_cnt0 !== 16'd0 || frame_cnt1 !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", frame_cnt0, frame_cnt1); end
    rst = 1'b0; m_last = 1'b1; m_cnt = '{0, 0};
    req = 2'b11; tick;
    checks++; if (arb_state !== 3'd1 || src_sel !== 1'b0) begin errors++; $display("FAIL rst_first_arb: state=%0d sel=%b want 1/0", arb_state, src_sel); end
    req = 2'b00; tick;
    checks++; if (arb_state !== 3'd0) begin errors++; $display("FAIL rst_withdraw: got %0d want 0", arb_state); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g [3] = '{2'b01, 2'b10, 2'b01};
    logic [1:0] g;
    for (int k = 0; k < 3; k++) begin
      run_frame(2'b11, 0, 1'b0, 1'b0, 2 + k, g);
      checks++; if (g !== exp_g[k]) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, g, exp_g[k]); end
    end
    req = 2'b00;
    checks++; if (frame_cnt0 !== 16'd2 || frame_cnt1 !== 16'd1) begin errors++; $display("FAIL rr_counts: got %0d/%0d want 2/1", frame_cnt0, frame_cnt1); end
  endtask

  task automatic test_random;
    logic [1:0] g;
    logic [1:0] r;
    int b;
    bit f;
    done_cyc = -1;
    for (int it = 0; it < 25; it++) begin
      r = 2'($urandom_range(1, 3));
      b = int'($urandom_range(0, 2));
      f = (done_cyc >= 0) && (b == 0) && ($urandom_range(1) == 1);
      run_frame(r, b, f, 1'($urandom_range(1)), int'($urandom_range(0, 6)), g);
    end
    req = 2'b00;
    tick;
  endtask

  task automatic test_watchdog;
    bit bad = 1'b0;
    req = 2'b01; tick;
    sync_ext = 1'b0; tick; tick;
    sync_ext = 1'b1; tick;
`ifdef CL_ARB_TIMEOUT_EN
    for (int i = 0; i < 99; i++) begin
      tick;
      if (timeout_err !== 1'b0 || arb_state !== 3'd3) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL wd_early: timeout_err or state left BUSY before cycle 100"); end
    tick;
    checks++; if (timeout_err !== 1'b1 || arb_state !== 3'd4 || grant !== 2'b00) begin errors++; $display("FAIL wd_fire: err=%b state=%0d grant=%b want 1/4/00", timeout_err, arb_state, grant); end
    checks++; if (frame_cnt0 !== 16'(m_cnt[0]) || frame_cnt1 !== 16'(m_cnt[1])) begin errors++; $display("FAIL wd_count: got %0d/%0d want %0d/%0d", frame_cnt0, frame_cnt1, m_cnt[0], m_cnt[1]); end
    req = 2'b00;
    repeat (GC) tick;
    checks++; if (arb_state !== 3'd0 || timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: state=%0d err=%b want 0/1", arb_state, timeout_err); end
`else
    for (int i = 0; i < 150; i++) begin
      tick;
      if (timeout_err !== 1'b0 || arb_state !== 3'd3 || grant !== 2'b01) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL long_busy: BUSY not held for 150 cycles without frame_done"); end
    frame_done = 1'b1; tick; frame_done = 1'b0;
    m_cnt[0]++; m_last = 1'b0;
    checks++; if (frame_cnt0 !== 16'(m_cnt[0]) || arb_state !== 3'd4) begin errors++; $display("FAIL long_done: cnt0=%0d state=%0d want %0d/4", frame_cnt0, arb_state, m_cnt[0]); end
    req = 2'b00;
    repeat (GC) tick;
    checks++; if (arb_state !== 3'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL long_idle: state=%0d err=%b want 0/0", arb_state, timeout_err); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset;
    test_internal_sync;
    test_withdraw;
    test_pause_sync;
    test_reset_mid_busy;
    test_round_robin;
    test_random;
    test_watchdog;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
